// File: rtl/mips8_sequencer.sv
// Multi-cycle control sequencer for the 8-bit MIPS datapath (FETCH/DECODE/EXEC/MEM/WB).
// Latency excl. ack wait: R-type/ADDI 4, LW 5, SW 4, BEQ/JMP/NOP 3 cycles.
// Backpressure: holds if_req/dm_req until ack; optional watchdog SEQ_WATCHDOG_EN traps long stalls to ERROR.
module mips8_sequencer #(
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       op,
  input  logic [1:0]       fn,
  input  logic             zero_flag,
  output logic             if_req,
  input  logic             if_ack,
  output logic             dm_req,
  output logic             dm_we,
  input  logic             dm_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [2:0]       alu_fn,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [1:0] fn_q;
  logic       wdog_trip;

`ifdef SEQ_WATCHDOG_EN
  localparam int STALL_W = (WDOG_CYCLES > 255) ? $clog2(WDOG_CYCLES + 1) : 8;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(WDOG_CYCLES - 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stalling;

  assign stalling  = ((state_q == S_FETCH) && !if_ack) || ((state_q == S_MEM) && !dm_ack);
  assign wdog_trip = stalling && (stall_cnt == STALL_LAST);
  // ERROR is only left by reset, so the state itself is the sticky flag
  assign err       = (state_q == S_ERROR);

  // Stall counter: counts consecutive unacked request cycles, zero whenever not stalling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stalling) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  // Without the watchdog the limit has no effect; handshakes wait forever
  assign wdog_trip = 1'b0 & (WDOG_CYCLES == 0);
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture opcode/function during DECODE; later states use only these copies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= 3'b000;
      fn_q <= 2'b00;
    end else if (state_q == S_DECODE) begin
      op_q <= op;
      fn_q <= fn;
    end
  end

  // Retired-instruction counter: one count per PC update, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (pc_en) begin
      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic plus handshake and strobe outputs
  always_comb begin
    state_d    = state_q;
    if_req     = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if_req = 1'b1;
        if (if_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wdog_trip) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          OP_BEQ: begin
            pc_en   = 1'b1;
            pc_sel  = zero_flag;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_en   = 1'b1;
            pc_sel  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = (op_q == OP_SW);
        if (dm_ack) begin
          if (op_q == OP_SW) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wdog_trip) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        pc_en      = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // Datapath selects: Moore on latched opcode, held constant EXEC through WB
  always_comb begin
    alu_fn  = 3'b000;
    alu_src = 1'b0;
    reg_dst = 1'b0;
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      case (op_q)
        OP_R: begin
          alu_fn  = {1'b0, fn_q};
          reg_dst = 1'b1;
        end
        OP_ADDI, OP_LW, OP_SW: alu_src = 1'b1;
        OP_BEQ:                alu_fn  = 3'b001;
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mips8_sequencer.sv
// Directed bench for mips8_sequencer: walks each opcode class through the FSM.
// Inputs are driven 1ns after the rising edge and outputs checked 1ns later.
// Watchdog scenario runs only when SEQ_WATCHDOG_EN is defined.
module tb_mips8_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, zero_flag, if_ack, dm_ack;
  logic [2:0]  op;
  logic [1:0]  fn;
  logic        if_req, dm_req, dm_we, ir_load, pc_en, pc_sel, reg_write;
  logic        reg_dst, alu_src, mem_to_reg, halted, err;
  logic [2:0]  alu_fn, state_o;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  mips8_sequencer #(.CNT_W(16), .WDOG_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .run(run), .op(op), .fn(fn), .zero_flag(zero_flag),
    .if_req(if_req), .if_ack(if_ack), .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
    .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_fn(alu_fn), .mem_to_reg(mem_to_reg),
    .halted(halted), .err(err), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH (1ns after edge); leaves in EXEC with inputs just updated
  task automatic fetch(input logic [2:0] o, input logic [1:0] f, input int stall);
    for (int i = 0; i < stall; i++) begin
      #1;
      check("fetch_wait_state", {29'd0, state_o}, 32'd1);
      check("fetch_wait_ireq", {31'd0, if_req}, 32'd1);
      check("fetch_wait_irld", {31'd0, ir_load}, 32'd0);
      tick();
    end
    if_ack = 1'b1;
    op = o;
    fn = f;
    #1;
    check("fetch_ack_state", {29'd0, state_o}, 32'd1);
    check("fetch_ack_irld", {31'd0, ir_load}, 32'd1);
    tick();
    if_ack = 1'b0;
    #1;
    check("decode_state", {29'd0, state_o}, 32'd2);
    tick();
    op = ~o;
    fn = ~f;
    #1;
    check("exec_state", {29'd0, state_o}, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; run = 1'b0; op = 3'b000; fn = 2'b00;
    zero_flag = 1'b0; if_ack = 1'b0; dm_ack = 1'b0;
    tick(); tick();
    check("rst_state", {29'd0, state_o}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ifreq", {31'd0, if_req}, 32'd0);
    check("rst_dmreq", {31'd0, dm_req}, 32'd0);
    check("rst_pcen", {31'd0, pc_en}, 32'd0);

    // ADDI with two stall cycles: states 1,1,1,2,3,5,1
    reset = 1'b1; run = 1'b1;
    #1;
    check("idle_ifreq", {31'd0, if_req}, 32'd0);
    tick();
    fetch(3'b001, 2'b00, 2);
    check("addi_exec_src", {31'd0, alu_src}, 32'd1);
    check("addi_exec_fn", {29'd0, alu_fn}, 32'd0);
    check("addi_exec_pcen", {31'd0, pc_en}, 32'd0);
    tick();
    check("addi_wb_state", {29'd0, state_o}, 32'd5);
    check("addi_wb_regw", {31'd0, reg_write}, 32'd1);
    check("addi_wb_src", {31'd0, alu_src}, 32'd1);
    check("addi_wb_dst", {31'd0, reg_dst}, 32'd0);
    check("addi_wb_m2r", {31'd0, mem_to_reg}, 32'd0);
    check("addi_wb_pcen", {31'd0, pc_en}, 32'd1);
    check("addi_wb_pcsel", {31'd0, pc_sel}, 32'd0);
    tick();
    check("addi_next_state", {29'd0, state_o}, 32'd1);
    check("addi_retired", {16'd0, retired}, 32'd1);

    // R-type fn=10, run dropped mid-stream has no effect
    run = 1'b0;
    fetch(3'b000, 2'b10, 0);
    check("r_exec_fn", {29'd0, alu_fn}, 32'd2);
    check("r_exec_dst", {31'd0, reg_dst}, 32'd1);
    check("r_exec_src", {31'd0, alu_src}, 32'd0);
    tick();
    check("r_wb_fn", {29'd0, alu_fn}, 32'd2);
    check("r_wb_regw", {31'd0, reg_write}, 32'd1);
    check("r_wb_dst", {31'd0, reg_dst}, 32'd1);
    tick();
    check("r_retired", {16'd0, retired}, 32'd2);

    // LW with dm_ack on the fourth MEM cycle
    fetch(3'b010, 2'b00, 0);
    check("lw_exec_src", {31'd0, alu_src}, 32'd1);
    check("lw_exec_pcen", {31'd0, pc_en}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dm_ack = 1'b1;
      #1;
      check("lw_mem_state", {29'd0, state_o}, 32'd4);
      check("lw_mem_req", {31'd0, dm_req}, 32'd1);
      check("lw_mem_we", {31'd0, dm_we}, 32'd0);
      check("lw_mem_pcen", {31'd0, pc_en}, 32'd0);
      tick();
    end
    dm_ack = 1'b0;
    #1;
    check("lw_wb_state", {29'd0, state_o}, 32'd5);
    check("lw_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
    check("lw_wb_regw", {31'd0, reg_write}, 32'd1);
    check("lw_wb_pcen", {31'd0, pc_en}, 32'd1);
    tick();
    check("lw_retired", {16'd0, retired}, 32'd3);

    // SW acked immediately
    fetch(3'b011, 2'b00, 1);
    tick();
    dm_ack = 1'b1;
    #1;
    check("sw_mem_req", {31'd0, dm_req}, 32'd1);
    check("sw_mem_we", {31'd0, dm_we}, 32'd1);
    check("sw_mem_pcen", {31'd0, pc_en}, 32'd1);
    check("sw_mem_pcsel", {31'd0, pc_sel}, 32'd0);
    check("sw_mem_regw", {31'd0, reg_write}, 32'd0);
    tick();
    dm_ack = 1'b0;
    #1;
    check("sw_next_state", {29'd0, state_o}, 32'd1);
    check("sw_retired", {16'd0, retired}, 32'd4);

    // BEQ taken, BEQ not taken, JMP, NOP: {op, zero_flag, expected pc_sel}
    for (int k = 0; k < 4; k++) begin
      logic [2:0] o;
      logic       z, sel;
      case (k)
        0:       begin o = 3'b100; z = 1'b1; sel = 1'b1; end
        1:       begin o = 3'b100; z = 1'b0; sel = 1'b0; end
        2:       begin o = 3'b101; z = 1'b0; sel = 1'b1; end
        default: begin o = 3'b111; z = 1'b1; sel = 1'b0; end
      endcase
      fetch(o, 2'b00, 0);
      zero_flag = z;
      #1;
      check("br_exec_pcen", {31'd0, pc_en}, 32'd1);
      check("br_exec_pcsel", {31'd0, pc_sel}, {31'd0, sel});
      check("br_exec_fn", {29'd0, alu_fn}, (o == 3'b100) ? 32'd1 : 32'd0);
      tick();
      zero_flag = 1'b0;
      check("br_next_state", {29'd0, state_o}, 32'd1);
      check("br_retired", {16'd0, retired}, 32'd5 + k);
    end

    // HALT: no PC update, sticky, ignores run
    fetch(3'b110, 2'b00, 0);
    check("halt_exec_pcen", {31'd0, pc_en}, 32'd0);
    tick();
    check("halt_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      #1;
      check("halt_state", {29'd0, state_o}, 32'd6);
      check("halt_pcen", {31'd0, pc_en}, 32'd0);
      tick();
    end
    check("halt_retired", {16'd0, retired}, 32'd8);

    // Reset in the middle of an LW memory handshake
    reset = 1'b0; run = 1'b0;
    tick();
    reset = 1'b1; run = 1'b1;
    tick();
    fetch(3'b010, 2'b00, 0);
    tick();
    check("rmem_req", {31'd0, dm_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("rmem_req_drop", {31'd0, dm_req}, 32'd0);
    check("rmem_state", {29'd0, state_o}, 32'd0);
    run = 1'b0;
    dm_ack = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("rmem_ack_state", {29'd0, state_o}, 32'd0);
    check("rmem_ack_regw", {31'd0, reg_write}, 32'd0);
    check("rmem_ack_pcen", {31'd0, pc_en}, 32'd0);
    tick();
    dm_ack = 1'b0;
    #1;
    check("rmem_after_state", {29'd0, state_o}, 32'd0);
    check("rmem_retired", {16'd0, retired}, 32'd0);

    // Fetch that is never acknowledged
    run = 1'b1;
    tick();
`ifdef SEQ_WATCHDOG_EN
    for (int i = 0; i < 8; i++) begin
      check("wd_fetch_state", {29'd0, state_o}, 32'd1);
      check("wd_err_low", {31'd0, err}, 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("wd_error_state", {29'd0, state_o}, 32'd7);
      check("wd_err", {31'd0, err}, 32'd1);
      check("wd_ifreq", {31'd0, if_req}, 32'd0);
      tick();
    end
`else
    for (int i = 0; i < 30; i++) begin
      check("nowd_fetch_state", {29'd0, state_o}, 32'd1);
      check("nowd_err", {31'd0, err}, 32'd0);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
